// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential DIV/MOD unit.
package alu_pkg;

    localparam int DIV_W     = 16;
    localparam int DIV_CNT_W = 4;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIN
    } div_state_e;

    localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 16'hFFFF;

endpackage

// File: rtl/restoring_divider_16bit_cla.sv
// 16-bit carry-lookahead adder: lookahead across four nibbles, ripple inside each nibble.
module CLA_16bit_adder (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        p,
    output logic        g
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_cn;
    logic        w_c;

    assign w_g = in1 & in2;
    assign w_p = in1 ^ in2;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            assign w_gg[k] = w_g[4*k+3]
                           | (w_p[4*k+3] & w_g[4*k+2])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            assign w_gp[k] = &w_p[4*k+3:4*k];
        end
    endgenerate

    // Nibble carries depend only on group terms and c_in, never on each other.
    assign w_cn[0] = c_in;
    assign w_cn[1] = w_gg[0] | (w_gp[0] & c_in);
    assign w_cn[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c_in);
    assign w_cn[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);
    assign w_cn[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & c_in);

    always_comb begin
        sum = '0;
        w_c = 1'b0;
        for (int n = 0; n < 4; n++) begin
            w_c = w_cn[n];
            for (int j = 0; j < 4; j++) begin
                sum[4*n+j] = w_p[4*n+j] ^ w_c;
                w_c        = w_g[4*n+j] | (w_p[4*n+j] & w_c);
            end
        end
    end

    assign c_out = w_cn[4];
    assign p     = &w_gp;
    assign g     = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);

endmodule

// File: rtl/restoring_divider_16bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a CLA subtractor.
module restoring_divider_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e           r_state;
    logic [DIV_W-1:0]     r_rem;
    logic [DIV_W-1:0]     r_q;
    logic [DIV_W-1:0]     r_dsor;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [DIV_W-1:0]     r_quotient;
    logic [DIV_W-1:0]     r_remainder;
    logic                 r_dbz;

    logic [DIV_W:0]       w_p;
    logic [DIV_W-1:0]     w_trial;
    logic                 w_cout;
    logic                 w_no_borrow;
    logic [DIV_W-1:0]     w_r_next;
    logic [DIV_W-1:0]     w_q_next;
    logic [DIV_W-1:0]     w_d_inv;

    assign w_p     = {r_rem, r_q[DIV_W-1]};
    assign w_d_inv = ~r_dsor;

    CLA_16bit_adder u_sub (
        .in1   (w_p[DIV_W-1:0]),
        .in2   (w_d_inv),
        .c_in  (1'b1),
        .sum   (w_trial),
        .c_out (w_cout),
        .p     (),
        .g     ()
    );

    // A set P[16] means the partial remainder already exceeds any 16-bit divisor.
    assign w_no_borrow = w_cout | w_p[DIV_W];
    assign w_r_next    = w_no_borrow ? w_trial : w_p[DIV_W-1:0];
    assign w_q_next    = {r_q[DIV_W-2:0], w_no_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DIV_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_dsor      <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE, DIV_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= DIV_IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            r_quotient  <= DIV_ZERO_QUOT;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= DIV_FIN;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= dividend;
                            r_dsor  <= divisor;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + DIV_CNT_W'(1);
                    // Results are published only on the last iteration.
                    if (r_cnt == '1) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next;
                        r_dbz       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DIV_FIN;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider_16bit.sv
// Directed and randomised checks of the restoring divider: results, latency, protocol and reset.
module tb_restoring_divider_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    restoring_divider_16bit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Drives one start edge (T0) and returns 1 time unit after it.
    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Steps edges until done is seen (bounded); idx is the edge index relative to T0.
    task automatic wait_done(input int idx0, output int idx, output int busy_n);
        idx    = idx0;
        busy_n = 0;
        while (done !== 1'b1 && idx < 40) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            idx++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 35'b0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", {busy, done, quotient, remainder, div_by_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        logic [15:0] ta [5] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'd3, 16'd0};
        logic [15:0] tb [5] = '{16'd7,   16'd1,    16'hFFFF, 16'd10, 16'd5};
        logic [15:0] eq [5] = '{16'd14,  16'hFFFF, 16'd1,    16'd0,  16'd0};
        logic [15:0] er [5] = '{16'd2,   16'd0,    16'd0,    16'd3,  16'd0};
        int idx, bn;
        for (int i = 0; i < 5; i++) begin
            do_start(ta[i], tb[i]);
            wait_done(0, idx, bn);
            checks++;
            if (idx !== 16) begin
                errors++;
                $display("FAIL basic_latency[%0d] got %0d want 16", i, idx);
            end
            checks++;
            if (bn !== 16) begin
                errors++;
                $display("FAIL basic_busy_cycles[%0d] got %0d want 16", i, bn);
            end
            checks++;
            if ({quotient, remainder, div_by_zero} !== {eq[i], er[i], 1'b0}) begin
                errors++;
                $display("FAIL basic_result[%0d] got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=0",
                         i, quotient, remainder, div_by_zero, eq[i], er[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL basic_done_pulse[%0d] got done/busy=%b want 00", i, {done, busy});
            end
        end
    endtask

    task automatic test_div_zero();
        int idx, bn;
        do_start(16'd1234, 16'd0);
        wait_done(0, idx, bn);
        checks++;
        if (idx !== 0 || bn !== 0) begin
            errors++;
            $display("FAIL dbz_timing got idx=%0d busy_n=%0d want 0 0", idx, bn);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'd1234, 1'b1}) begin
            errors++;
            $display("FAIL dbz_result got q=%h r=%0d dbz=%0b want q=ffff r=1234 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, div_by_zero} !== 3'b001) begin
            errors++;
            $display("FAIL dbz_after got done/busy/dbz=%b want 001", {done, busy, div_by_zero});
        end
    endtask

    task automatic test_ignore_start();
        int idx, bn;
        do_start(16'd50, 16'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'd7;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy got %b want 1", busy);
        end
        wait_done(5, idx, bn);
        checks++;
        if (idx !== 16) begin
            errors++;
            $display("FAIL ignore_latency got %0d want 16", idx);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {16'd10, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result got q=%0d r=%0d dbz=%0b want q=10 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int idx, bn;
        do_start(16'd100, 16'd7);
        wait_done(0, idx, bn);
        dividend = 16'd9;
        divisor  = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder} !== {1'b1, 1'b0, 16'd14, 16'd2}) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b done=%b q=%0d r=%0d want 1 0 14 2",
                     busy, done, quotient, remainder);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder} !== {16'd14, 16'd2}) begin
            errors++;
            $display("FAIL b2b_held got q=%0d r=%0d want 14 2", quotient, remainder);
        end
        wait_done(8, idx, bn);
        checks++;
        if (idx !== 16 || {quotient, remainder, div_by_zero} !== {16'd2, 16'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_result got idx=%0d q=%0d r=%0d dbz=%0b want 16 2 1 0",
                     idx, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_mid();
        int idx, bn;
        do_start(16'd100, 16'd7);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 35'b0) begin
            errors++;
            $display("FAIL rst_mid_async got %h want 0", {busy, done, quotient, remainder, div_by_zero});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_hold[%0d] got busy/done=%b want 00", i, {busy, done});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(16'd200, 16'd9);
        wait_done(0, idx, bn);
        checks++;
        if (idx !== 16 || {quotient, remainder, div_by_zero} !== {16'd22, 16'd2, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_after got idx=%0d q=%0d r=%0d dbz=%0b want 16 22 2 0",
                     idx, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, mq, mr;
        logic        mz;
        int          mlat, idx, bn;
        for (int n = 0; n < 200; n++) begin
            a = 16'($urandom);
            if (n % 8 == 0)      b = 16'd0;
            else if (n % 3 == 0) b = 16'($urandom_range(1, 255));
            else                 b = 16'($urandom);
            if (b == 16'd0) begin
                mq = 16'hFFFF; mr = a; mz = 1'b1; mlat = 0;
            end else begin
                mq = a / b; mr = a % b; mz = 1'b0; mlat = 16;
            end
            do_start(a, b);
            wait_done(0, idx, bn);
            checks++;
            if (idx !== mlat || {quotient, remainder, div_by_zero} !== {mq, mr, mz}) begin
                errors++;
                $display("FAIL random[%0d] %0d/%0d got idx=%0d q=%0d r=%0d dbz=%0b want %0d %0d %0d %0b",
                         n, a, b, idx, quotient, remainder, div_by_zero, mlat, mq, mr, mz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
